// File: rtl/mmio_timer_responder.sv
// mmio_timer_responder
//   Responder for the machine-timer MMIO window on the CPU data memory port.
//   Owns mtime, mtimecmp and msip. Loads return data one cycle after the
//   request, which matches block RAM timing, so the top-level read mux can use
//   o_hit as its select alongside data BRAM.
//
//   Window layout (word index = addr[4:2]; addr[1:0] ignored):
//     0 MTIME_LO  1 MTIME_HI  2 MTIMECMP_LO  3 MTIMECMP_HI
//     4 MSIP (bit 0 only)     5..7 reserved (read 0, writes dropped)
//
//   Optional feature macro: MMIO_TIMER_PRESCALER_EN
//     defined   : mtime advances once every PRESCALE core clocks
//     undefined : mtime advances every clock and PRESCALE is ignored
//
// Parameters
//   BASE_ADDR  byte address of the window, 32-byte aligned
//   PRESCALE   core clocks per mtime tick, 1..65535 (prescaler build only)
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_data_mem_addr              byte address from the CPU
//   i_data_mem_wr_data           store data
//   i_data_mem_per_byte_wr_en    store byte lanes (lane k = bits [8k+7:8k])
//   i_data_mem_read_enable       load request
//   o_rd_data                    load data, valid the cycle after the request
//   o_hit                        previous-cycle request fell in the window
//   o_mtime                      current mtime
//   o_timer_irq                  registered mtime >= mtimecmp
//   o_sw_irq                     msip bit 0
module mmio_timer_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          PRESCALE  = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_data_mem_addr,
  input  logic [31:0] i_data_mem_wr_data,
  input  logic [3:0]  i_data_mem_per_byte_wr_en,
  input  logic        i_data_mem_read_enable,
  output logic [31:0] o_rd_data,
  output logic        o_hit,
  output logic [63:0] o_mtime,
  output logic        o_timer_irq,
  output logic        o_sw_irq
);

  localparam int NUM_LANES = 4;

  typedef enum logic [2:0] {
    W_MTIME_LO    = 3'd0,
    W_MTIME_HI    = 3'd1,
    W_MTIMECMP_LO = 3'd2,
    W_MTIMECMP_HI = 3'd3,
    W_MSIP        = 3'd4
  } word_e;

  typedef struct packed {
    logic                 win;
    logic [2:0]           idx;
    logic                 rd;
    logic                 wr;
    logic [NUM_LANES-1:0] be;
    logic [31:0]          data;
  } req_t;

  // Timer state, stored as {hi, lo} words so the byte-lane merge can pick
  // a word by index.
  logic [1:0][31:0] mtime, mtime_nxt;
  logic [1:0][31:0] mtimecmp, mtimecmp_nxt;
  logic             msip, msip_nxt;

  req_t        req;
  logic        time_wr;
  logic        tick;
  logic [31:0] rd_word;

  // Byte-lane merge: enabled lanes take the store data, others keep old.
  function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                             input logic [31:0] data,
                                             input logic [NUM_LANES-1:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < NUM_LANES; k++)
      if (be[k]) r[8*k +: 8] = data[8*k +: 8];
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  always_comb begin
    req      = '0;
    req.win  = (i_data_mem_addr[31:5] == BASE_ADDR[31:5]);
    req.idx  = i_data_mem_addr[4:2];
    req.be   = i_data_mem_per_byte_wr_en;
    req.data = i_data_mem_wr_data;
    req.rd   = req.win & i_data_mem_read_enable;
    req.wr   = req.win & (|i_data_mem_per_byte_wr_en);
  end

  // Any store to either mtime half freezes the whole counter for that cycle.
  assign time_wr = req.wr & ((req.idx == W_MTIME_LO) | (req.idx == W_MTIME_HI));

  // ---------------------------------------------------------------------
  // Tick generation
  // ---------------------------------------------------------------------
`ifdef MMIO_TIMER_PRESCALER_EN
  logic [15:0] presc_cnt;
  logic        presc_wrap;

  assign presc_wrap = (presc_cnt == 16'(PRESCALE - 1));
  assign tick       = presc_wrap;

  // A store to mtime restarts the prescale period so the written value is
  // held for a full PRESCALE clocks before the next tick.
  always_ff @(posedge i_clk) begin
    if (i_rst)                     presc_cnt <= '0;
    else if (time_wr | presc_wrap) presc_cnt <= '0;
    else                           presc_cnt <= presc_cnt + 16'd1;
  end

  logic unused_bits;
  assign unused_bits = ^i_data_mem_addr[1:0];
`else
  assign tick = 1'b1;

  logic unused_bits;
  assign unused_bits = ^{i_data_mem_addr[1:0], 32'(PRESCALE)};
`endif

  // ---------------------------------------------------------------------
  // Next-state for timer registers
  // ---------------------------------------------------------------------
  always_comb begin
    mtime_nxt    = mtime;
    mtimecmp_nxt = mtimecmp;
    msip_nxt     = msip;
    if (time_wr)
      mtime_nxt[req.idx[0]] = lane_merge(mtime[req.idx[0]], req.data, req.be);
    else if (tick)
      mtime_nxt = mtime + 64'd1;  // wraps silently at 2^64
    if (req.wr) begin
      case (req.idx)
        W_MTIMECMP_LO: mtimecmp_nxt[0] = lane_merge(mtimecmp[0], req.data, req.be);
        W_MTIMECMP_HI: mtimecmp_nxt[1] = lane_merge(mtimecmp[1], req.data, req.be);
        W_MSIP:        if (req.be[0]) msip_nxt = req.data[0];
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Read mux: uses current register values, so a same-cycle store to the
  // same word is not visible to the load (read-before-write).
  // ---------------------------------------------------------------------
  always_comb begin
    rd_word = '0;
    case (req.idx)
      W_MTIME_LO:    rd_word = mtime[0];
      W_MTIME_HI:    rd_word = mtime[1];
      W_MTIMECMP_LO: rd_word = mtimecmp[0];
      W_MTIMECMP_HI: rd_word = mtimecmp[1];
      W_MSIP:        rd_word = {31'd0, msip};
      default:       rd_word = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // State and response registers
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mtime       <= '0;
      mtimecmp    <= '1;
      msip        <= 1'b0;
      o_rd_data   <= '0;
      o_hit       <= 1'b0;
      o_timer_irq <= 1'b0;
    end else begin
      mtime       <= mtime_nxt;
      mtimecmp    <= mtimecmp_nxt;
      msip        <= msip_nxt;
      o_rd_data   <= req.rd ? rd_word : 32'd0;
      o_hit       <= req.rd | req.wr;
      // Compare the values held at this edge; the irq therefore lags the
      // tick or store that caused it by exactly one cycle.
      o_timer_irq <= (mtime >= mtimecmp);
    end
  end

  assign o_mtime  = mtime;
  assign o_sw_irq = msip;

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Bench for mmio_timer_responder: a table of directed vectors, hand-written
// timer/irq sequences, then randomized traffic against a reference model.
module tb_mmio_timer_responder;

  localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef MMIO_TIMER_PRESCALER_EN
  localparam int PRESC = 4;
`else
  localparam int PRESC = 1;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_data_mem_addr = '0;
  logic [31:0] i_data_mem_wr_data = '0;
  logic [3:0]  i_data_mem_per_byte_wr_en = '0;
  logic        i_data_mem_read_enable = 1'b0;
  logic [31:0] o_rd_data;
  logic        o_hit;
  logic [63:0] o_mtime;
  logic        o_timer_irq;
  logic        o_sw_irq;

  mmio_timer_responder #(.BASE_ADDR(BASE), .PRESCALE(PRESC)) dut (
    .i_clk                     (i_clk),
    .i_rst                     (i_rst),
    .i_data_mem_addr           (i_data_mem_addr),
    .i_data_mem_wr_data        (i_data_mem_wr_data),
    .i_data_mem_per_byte_wr_en (i_data_mem_per_byte_wr_en),
    .i_data_mem_read_enable    (i_data_mem_read_enable),
    .o_rd_data                 (o_rd_data),
    .o_hit                     (o_hit),
    .o_mtime                   (o_mtime),
    .o_timer_irq               (o_timer_irq),
    .o_sw_irq                  (o_sw_irq)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural state plus expected registered outputs.
  logic [63:0] m_time, m_cmp;
  logic        m_msip;
  int          m_pcnt;
  logic [31:0] e_rd;
  logic        e_hit, e_irq;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] put_bytes(input logic [31:0] old, input logic [31:0] d,
                                            input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    case (idx)
      0: return m_time[31:0];
      1: return m_time[63:32];
      2: return m_cmp[31:0];
      3: return m_cmp[63:32];
      4: return {31'd0, m_msip};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge(input bit rst, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] wen, input bit re);
    bit win;
    int idx;
    if (rst) begin
      m_time = 0; m_cmp = '1; m_msip = 0; m_pcnt = 0;
      e_rd = 0; e_hit = 0; e_irq = 0;
      return;
    end
    win   = (addr[31:5] == BASE[31:5]);
    idx   = int'(addr[4:2]);
    e_rd  = (win && re) ? model_read(idx) : 32'd0;
    e_hit = win && (re || wen != 0);
    e_irq = (m_time >= m_cmp);
    if (win && wen != 0) begin
      case (idx)
        0: m_time[31:0]  = put_bytes(m_time[31:0], wd, wen);
        1: m_time[63:32] = put_bytes(m_time[63:32], wd, wen);
        2: m_cmp[31:0]   = put_bytes(m_cmp[31:0], wd, wen);
        3: m_cmp[63:32]  = put_bytes(m_cmp[63:32], wd, wen);
        4: if (wen[0]) m_msip = wd[0];
        default: ;
      endcase
    end
    if (win && wen != 0 && idx < 2) m_pcnt = 0;
    else if (m_pcnt == PRESC - 1) begin m_pcnt = 0; m_time = m_time + 64'd1; end
    else m_pcnt++;
  endtask

  // One clock: drive, advance model at the edge, compare 1 time unit later.
  task automatic step(input bit rst, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] wen, input bit re);
    i_rst = rst; i_data_mem_addr = addr; i_data_mem_wr_data = wd;
    i_data_mem_per_byte_wr_en = wen; i_data_mem_read_enable = re;
    @(posedge i_clk);
    model_edge(rst, addr, wd, wen, re);
    #1;
    chk("m_rd_data", 64'(o_rd_data), 64'(e_rd));
    chk("m_hit", 64'(o_hit), 64'(e_hit));
    chk("m_timer_irq", 64'(o_timer_irq), 64'(e_irq));
    chk("m_sw_irq", 64'(o_sw_irq), 64'(m_msip));
    chk("m_mtime", o_mtime, m_time);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 32'h0, 32'h0, 4'h0, 0);
  endtask

  typedef struct {
    bit          rst;
    int          pre_idle;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wen;
    bit          re;
    logic [31:0] exp_rd;
    bit          exp_hit;
    string       nm;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int found;
    // Directed vectors; expected values written from the register map.
    tbl.push_back('{1, 0, BASE+32'h00, 32'h0, 4'h0, 1, 32'h0, 0, "reset_read"});
    tbl.push_back('{0, 10, BASE+32'h00, 32'h0, 4'h0, 1, 32'(10/PRESC), 1, "mtime_lo_after_10"});
    tbl.push_back('{0, 0, BASE+32'h04, 32'h0, 4'h0, 1, 32'h0, 1, "mtime_hi"});
    tbl.push_back('{0, 0, BASE+32'h0C, 32'h0, 4'h0, 1, 32'hFFFF_FFFF, 1, "cmp_hi_reset"});
    tbl.push_back('{0, 0, BASE+32'h08, 32'h1234_5678, 4'b0100, 0, 32'h0, 1, "cmp_lo_lane2_wr"});
    tbl.push_back('{0, 0, BASE+32'h08, 32'h0, 4'h0, 1, 32'hFF34_FFFF, 1, "cmp_lo_lane2_rd"});
    tbl.push_back('{0, 0, BASE+32'h14, 32'h0, 4'h0, 1, 32'h0, 1, "reserved_rd"});
    tbl.push_back('{0, 0, BASE+32'h20, 32'hFFFF_FFFF, 4'hF, 1, 32'h0, 0, "outside_rdwr"});
    tbl.push_back('{0, 0, BASE+32'h08, 32'h0, 4'h0, 1, 32'hFF34_FFFF, 1, "cmp_lo_unchanged"});
    tbl.push_back('{0, 0, BASE+32'h1C, 32'hFFFF_FFFF, 4'hF, 1, 32'h0, 1, "reserved_rdwr"});
    tbl.push_back('{0, 0, BASE+32'h10, 32'hAABB_CCDD, 4'b0001, 0, 32'h0, 1, "msip_wr"});
    tbl.push_back('{0, 0, BASE+32'h13, 32'h0, 4'h0, 1, 32'h1, 1, "msip_rd_lowbits"});
    tbl.push_back('{0, 0, BASE+32'h10, 32'h0, 4'hF, 1, 32'h1, 1, "msip_rbw"});
    tbl.push_back('{0, 0, BASE+32'h10, 32'h0, 4'h0, 1, 32'h0, 1, "msip_cleared"});
    tbl.push_back('{0, 0, BASE+32'h10, 32'h1, 4'hF, 0, 32'h0, 1, "msip_set"});
    tbl.push_back('{1, 0, BASE+32'h10, 32'h0, 4'h0, 1, 32'h0, 0, "rst_drops_req"});
    tbl.push_back('{0, 0, BASE+32'h10, 32'h0, 4'h0, 1, 32'h0, 1, "msip_after_rst"});

    for (int v = 0; v < tbl.size(); v++) begin
      idle(tbl[v].pre_idle);
      step(tbl[v].rst, tbl[v].addr, tbl[v].wdata, tbl[v].wen, tbl[v].re);
      chk({tbl[v].nm, "_rd"}, 64'(o_rd_data), 64'(tbl[v].exp_rd));
      chk({tbl[v].nm, "_hit"}, 64'(o_hit), 64'(tbl[v].exp_hit));
      if (tbl[v].rst) begin
        chk({tbl[v].nm, "_mtime0"}, o_mtime, 64'h0);
        chk({tbl[v].nm, "_irq0"}, 64'(o_timer_irq), 64'h0);
        chk({tbl[v].nm, "_sw0"}, 64'(o_sw_irq), 64'h0);
      end
    end

    // Timer irq rises one cycle after mtime reaches mtimecmp, falls one
    // cycle after mtimecmp is raised.
    step(1, 32'h0, 32'h0, 4'h0, 0);
    step(0, BASE+32'h08, 32'h0000_0020, 4'hF, 0);
    step(0, BASE+32'h0C, 32'h0, 4'hF, 0);
    found = 0;
    for (int i = 0; i < 100 * PRESC && found == 0; i++) begin
      idle(1);
      if (o_mtime == 64'h20) found = 1;
    end
    chk("irq_reached_cmp", 64'(found), 64'h1);
    chk("irq_low_at_equal", 64'(o_timer_irq), 64'h0);
    idle(1);
    chk("irq_rise", 64'(o_timer_irq), 64'h1);
    step(0, BASE+32'h0C, 32'hFFFF_FFFF, 4'hF, 0);
    chk("irq_hold_on_write", 64'(o_timer_irq), 64'h1);
    idle(1);
    chk("irq_fall", 64'(o_timer_irq), 64'h0);

    // Software irq through a single byte lane.
    step(0, BASE+32'h10, 32'hAABB_CCDD, 4'b0001, 0);
    chk("sw_irq_set", 64'(o_sw_irq), 64'h1);
    step(0, BASE+32'h10, 32'h0, 4'h0, 1);
    chk("msip_read", 64'(o_rd_data), 64'h1);
    step(0, BASE+32'h10, 32'h0, 4'hF, 0);
    chk("sw_irq_clr", 64'(o_sw_irq), 64'h0);

    // mtime wrap at 2^64.
    step(0, BASE+32'h04, 32'hFFFF_FFFF, 4'hF, 0);
    step(0, BASE+32'h00, 32'hFFFF_FFFE, 4'hF, 0);
    chk("wrap_written", o_mtime, 64'hFFFF_FFFF_FFFF_FFFE);
    idle(PRESC);
    chk("wrap_max", o_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(PRESC);
    chk("wrap_zero", o_mtime, 64'h0);

`ifdef MMIO_TIMER_PRESCALER_EN
    step(1, 32'h0, 32'h0, 4'h0, 0);
    idle(12);
    chk("presc_12_cycles", o_mtime, 64'h3);
    idle(2);
    step(1, 32'h0, 32'h0, 4'h0, 0);
    chk("presc_rst_mtime", o_mtime, 64'h0);
    idle(PRESC - 1);
    chk("presc_rst_hold", o_mtime, 64'h0);
    idle(1);
    chk("presc_rst_count", o_mtime, 64'h1);
`endif

    // Randomized traffic, mostly in-window, with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, d;
      logic [3:0]  we;
      bit          r, rs;
      int          kind;
      rs   = ($urandom_range(0, 99) == 0);
      kind = $urandom_range(0, 9);
      if (kind < 7)      a = {BASE[31:5], 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      else if (kind < 9) a = BASE + 32'h20 + 32'($urandom_range(0, 63));
      else               a = $urandom;
      we = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      r  = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       d = 32'($urandom_range(0, 255));
        1:       d = 32'hFFFF_FFFF;
        default: d = $urandom;
      endcase
      step(rs, a, d, we, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_timer_responder.md
Name: mmio_timer_responder

Overview:
- Responder side of the CPU data memory port for the machine-timer MMIO window.
- Decodes CPU loads and stores against a 32-byte window and returns read data with 1-cycle latency, matching block RAM timing.
- Owns mtime, mtimecmp and msip; drives the CPU's i_mtime input and the timer/software bits of i_interrupts.
- Replaces the constant mtime and interrupt values used in simulation; sits beside data BRAM, and the top-level read mux selects it by address.

Parameters:
- BASE_ADDR, 32'h4000_0000, byte address of the window; must be 32-byte aligned.
- PRESCALE, 1, core clocks per mtime tick; legal range 1..65535. Used only with the optional feature.

Ports:
- i_clk  input  1  core clock
- i_rst  input  1  synchronous active-high reset
- i_data_mem_addr  input  32  byte address from CPU
- i_data_mem_wr_data  input  32  store data
- i_data_mem_per_byte_wr_en  input  4  store byte lanes; lane k = bits [8k+7:8k]
- i_data_mem_read_enable  input  1  load request
- o_rd_data  output  32  load response, valid the cycle after the request
- o_hit  output  1  registered; 1 when the previous-cycle request fell in the window (mux select)
- o_mtime  output  64  current mtime
- o_timer_irq  output  1  machine timer interrupt pending
- o_sw_irq  output  1  machine software interrupt pending (msip bit 0)

Behaviour:
- Decode: in_win = (addr[31:5] == BASE_ADDR[31:5]). Word index = addr[4:2]; addr[1:0] ignored.
- Register map (word index):
  - 0 = MTIME_LO
  - 1 = MTIME_HI
  - 2 = MTIMECMP_LO
  - 3 = MTIMECMP_HI
  - 4 = MSIP, bit 0 only; other bits read 0
  - 5..7 = reserved; read 0, writes ignored
- Reset values:
  - mtime = 0; mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF; msip = 0
  - o_rd_data = 0, o_hit = 0, o_timer_irq = 0, o_sw_irq = 0
- Writes: any wr_en lane set and in_win. Only the enabled byte lanes of the selected word update; other lanes hold. Writes outside the window are ignored.
- Reads: when read_enable is set, o_rd_data <= selected word on the next edge.
  - Out-of-window or no read: o_rd_data <= 0.
  - o_hit <= in_win & (read_enable | any wr_en).
- Read/write in the same cycle to the same word: the read returns the pre-write value (read-before-write).
- mtime increments by 1 every cycle, wrapping 2^64-1 -> 0 with no flag.
  - A write to MTIME_LO or MTIME_HI in a cycle suppresses that cycle's increment for all 64 bits; the written lanes take the written value and the rest hold.
  - The read value of MTIME_* is the value before that edge's increment.
- o_timer_irq is registered: o_timer_irq <= (mtime >= mtimecmp), using register values at the edge, unsigned 64-bit compare. It lags a causative write or tick by exactly 1 cycle. It is level-sensitive: it clears only when mtimecmp is raised or mtime wraps.
- o_sw_irq equals msip bit 0 directly (a register, so 1 cycle after the store).
- o_mtime equals the mtime register.
- Reset mid-operation: all state returns to reset values at that edge; a request presented in the reset cycle is dropped, and o_rd_data = 0 on the following cycle.
- No stall or back-pressure: every request completes in 1 cycle.

Optional Feature:
- Macro: MMIO_TIMER_PRESCALER_EN.
- Defined:
  - A 16-bit prescale counter counts 0..PRESCALE-1 and mtime increments only on the wrap cycle.
  - Writes to MTIME_* reset the prescale counter to 0.
  - Reset clears the counter.
  - PRESCALE=1 is cycle-identical to undefined.
- Undefined: the counter is absent and mtime increments every cycle; the PRESCALE value is ignored.

Test Plan:
- Reset release, 10 idle cycles, then load BASE+0x0 -> the next cycle o_rd_data = 10 and o_hit = 1; o_timer_irq = 0; o_sw_irq = 0.
- Store 32'h0000_0020 to BASE+0x8, store 0 to BASE+0xC, with mtime below 0x20 -> o_timer_irq rises exactly 1 cycle after mtime first equals 0x20. Then store 0xFFFF_FFFF to BASE+0xC -> irq falls 1 cycle later.
- Store 32'hAABB_CCDD to BASE+0x10 with wr_en 4'b0001 -> o_sw_irq = 1 (0xDD bit 0 = 1); load returns 32'h0000_0001. Store 0 -> o_sw_irq = 0.
- Store 32'hFFFF_FFFF to MTIME_HI and 32'hFFFF_FFFE to MTIME_LO -> o_mtime reads FFFF_FFFF_FFFF_FFFE, then ...FFFF, then wraps to 0 two cycles after the last write.
- Byte-lane write 32'h1234_5678 with wr_en 4'b0100 to MTIMECMP_LO after reset -> reads 32'hFF34_FFFF. Load and store to BASE+0x20 -> o_rd_data = 0, o_hit = 0, no state change.
- With MMIO_TIMER_PRESCALER_EN and PRESCALE=4: 12 cycles after reset -> mtime = 3. Assert i_rst mid-count -> mtime = 0 and the prescale counter = 0 on the next cycle.
